// File: rtl/cache_port_arbiter_if.sv
// Bundle of the two requester ports, the cache-side request bus and the status
// signals of cache_port_arbiter. The arbiter uses the master view; the environment uses the slave view.
interface cache_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    // requester 0
    logic              req0_valid;
    logic              req0_type;
    logic [ADDR_W-1:0] req0_addr;
    logic [DATA_W-1:0] req0_wdata;
    logic              req0_ready;
    logic [DATA_W-1:0] req0_rdata;
    logic              req0_done;

    // requester 1
    logic              req1_valid;
    logic              req1_type;
    logic [ADDR_W-1:0] req1_addr;
    logic [DATA_W-1:0] req1_wdata;
    logic              req1_ready;
    logic [DATA_W-1:0] req1_rdata;
    logic              req1_done;

    // cache side
    logic              req_valid;
    logic              req_type;
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] data_out;
    logic              done_cache;

    // status
    logic              busy;
    logic [1:0]        grant;

    modport master (
        input  req0_valid, req0_type, req0_addr, req0_wdata,
        output req0_ready, req0_rdata, req0_done,
        input  req1_valid, req1_type, req1_addr, req1_wdata,
        output req1_ready, req1_rdata, req1_done,
        output req_valid, req_type, address, data_in,
        input  data_out, done_cache,
        output busy, grant
    );

    modport slave (
        output req0_valid, req0_type, req0_addr, req0_wdata,
        input  req0_ready, req0_rdata, req0_done,
        output req1_valid, req1_type, req1_addr, req1_wdata,
        input  req1_ready, req1_rdata, req1_done,
        input  req_valid, req_type, address, data_in,
        output data_out, done_cache,
        input  busy, grant
    );
endinterface

// File: rtl/cache_port_arbiter.sv
// Two-port arbiter in front of a single-transaction cache: one request in flight at a time.
// Define ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port 0 wins every tie.
module cache_port_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    cache_port_arbiter_if.master  bus
);
    localparam int NPORT = 2;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_reg;
    state_t            state_next;

    logic [NPORT-1:0]  valid_vec;
    logic [NPORT-1:0]  type_vec;
    logic [ADDR_W-1:0] addr_vec  [NPORT];
    logic [DATA_W-1:0] wdata_vec [NPORT];

    logic              any_valid;
    logic              accept;
    logic              complete;
    logic              win_idx;

    logic              owner_reg;
    logic              type_reg;
    logic [ADDR_W-1:0] addr_reg;
    logic [DATA_W-1:0] wdata_reg;

    logic [NPORT-1:0]  ready_vec;
    logic [NPORT-1:0]  done_reg;
    logic [DATA_W-1:0] rdata_reg [NPORT];

    logic              req_valid_c;
    logic              busy_c;
    logic [1:0]        grant_c;

    assign valid_vec    = {bus.req1_valid, bus.req0_valid};
    assign type_vec     = {bus.req1_type,  bus.req0_type};
    assign addr_vec[0]  = bus.req0_addr;
    assign addr_vec[1]  = bus.req1_addr;
    assign wdata_vec[0] = bus.req0_wdata;
    assign wdata_vec[1] = bus.req1_wdata;

    assign any_valid = |valid_vec;
    assign accept    = (state_reg == IDLE) && any_valid;
    assign complete  = (state_reg == BUSY) && bus.done_cache;

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_last_reg;

    // Reset value makes port 0 the first winner of a tie.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_last_reg <= 1'b1;
        end else if (accept) begin
            rr_last_reg <= win_idx;
        end
    end

    always_comb begin
        win_idx = 1'b0;
        if (valid_vec == 2'b11) begin
            win_idx = ~rr_last_reg;
        end else if (valid_vec[1]) begin
            win_idx = 1'b1;
        end
    end
`else
    always_comb begin
        win_idx = 1'b0;
        if (!valid_vec[0] && valid_vec[1]) begin
            win_idx = 1'b1;
        end
    end
`endif

    // FSM: state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // FSM: next state
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept)   state_next = BUSY;
            BUSY:    if (complete) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FSM: outputs. The rst term keeps ready low while reset is held.
    always_comb begin
        ready_vec   = '0;
        req_valid_c = 1'b0;
        busy_c      = 1'b0;
        grant_c     = 2'b00;
        case (state_reg)
            IDLE: begin
                if (rst && any_valid) begin
                    ready_vec[win_idx] = 1'b1;
                end
            end
            BUSY: begin
                req_valid_c = 1'b1;
                busy_c      = 1'b1;
                grant_c     = owner_reg ? 2'b10 : 2'b01;
            end
            default: ;
        endcase
    end

    // Request latch: captured on the accept edge and held for the whole cache transaction.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner_reg <= 1'b0;
            type_reg  <= 1'b0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else if (accept) begin
            owner_reg <= win_idx;
            type_reg  <= type_vec[win_idx];
            addr_reg  <= addr_vec[win_idx];
            wdata_reg <= wdata_vec[win_idx];
        end
    end

    // Per-port completion: read word captured with done_cache, done pulses one cycle later.
    generate
        for (genvar gi = 0; gi < NPORT; gi++) begin : g_port
            localparam logic PORT_ID = 1'(gi);
            logic port_complete;

            assign port_complete = complete && (owner_reg == PORT_ID);

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    done_reg[gi]  <= 1'b0;
                    rdata_reg[gi] <= '0;
                end else begin
                    done_reg[gi] <= port_complete;
                    if (port_complete) begin
                        rdata_reg[gi] <= bus.data_out;
                    end
                end
            end
        end
    endgenerate

    assign bus.req0_ready = ready_vec[0];
    assign bus.req1_ready = ready_vec[1];
    assign bus.req0_done  = done_reg[0];
    assign bus.req1_done  = done_reg[1];
    assign bus.req0_rdata = rdata_reg[0];
    assign bus.req1_rdata = rdata_reg[1];

    assign bus.req_valid  = req_valid_c;
    assign bus.req_type   = type_reg;
    assign bus.address    = addr_reg;
    assign bus.data_in    = wdata_reg;

    assign bus.busy       = busy_c;
    assign bus.grant      = grant_c;
endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter: single read, tie arbitration, write hold,
// back-to-back, stray done and reset in flight, with hand-computed expectations.
module tb_cache_port_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   total = 0;
    int   bad   = 0;

    cache_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    cache_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic set_req(input int p, input logic v, input logic t,
                           input logic [31:0] a, input logic [31:0] d);
        if (p == 0) begin
            bus.req0_valid = v; bus.req0_type = t; bus.req0_addr = a; bus.req0_wdata = d;
        end else begin
            bus.req1_valid = v; bus.req1_type = t; bus.req1_addr = a; bus.req1_wdata = d;
        end
    endtask

    function automatic logic get_ready(input int p);
        return (p == 0) ? bus.req0_ready : bus.req1_ready;
    endfunction

    function automatic logic get_done(input int p);
        return (p == 0) ? bus.req0_done : bus.req1_done;
    endfunction

    function automatic logic [31:0] get_rdata(input int p);
        return (p == 0) ? bus.req0_rdata : bus.req1_rdata;
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction; called at posedge+1 with the cache idle, returns at posedge+1.
    task automatic run_txn(input int p, input logic t, input logic [31:0] a,
                           input logic [31:0] d, input int lat, input logic [31:0] rd);
        logic       got_ready;
        int         waitc;
        logic [1:0] exp_grant;
        exp_grant = (p == 0) ? 2'b01 : 2'b10;
        set_req(p, 1'b1, t, a, d);
        got_ready = 1'b0;
        waitc     = 0;
        while (!got_ready && waitc < 10) begin
            @(negedge clk);
            got_ready = get_ready(p);
            if (!got_ready) begin
                next_cycle();
                waitc++;
            end
        end
        check("accept_ready", got_ready, 1'b1);
        check("accept_other_ready", get_ready(1 - p), 1'b0);
        check("accept_req_valid", bus.req_valid, 1'b0);
        next_cycle();
        set_req(p, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < lat; i++) begin
            @(negedge clk);
            check("busy_req_valid", bus.req_valid, 1'b1);
            check("busy_address", bus.address, a);
            check("busy_req_type", bus.req_type, t);
            if (t) check("busy_data_in", bus.data_in, d);
            check("busy_grant", bus.grant, exp_grant);
            check("busy_flag", bus.busy, 1'b1);
            check("busy_no_done", {bus.req1_done, bus.req0_done}, 2'b00);
            check("busy_no_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
            next_cycle();
        end
        bus.done_cache = 1'b1;
        bus.data_out   = rd;
        @(negedge clk);
        check("donecyc_req_valid", bus.req_valid, 1'b1);
        check("donecyc_address", bus.address, a);
        check("donecyc_no_done", get_done(p), 1'b0);
        next_cycle();
        bus.done_cache = 1'b0;
        bus.data_out   = 32'h0;
        @(negedge clk);
        check("done_pulse", get_done(p), 1'b1);
        check("done_other", get_done(1 - p), 1'b0);
        check("done_rdata", get_rdata(p), rd);
        check("done_req_valid", bus.req_valid, 1'b0);
        check("done_busy", bus.busy, 1'b0);
        check("done_grant", bus.grant, 2'b00);
        next_cycle();
        @(negedge clk);
        check("done_single_pulse", get_done(p), 1'b0);
        check("rdata_hold", get_rdata(p), rd);
        next_cycle();
        $display("txn port=%0d type=%0d addr=0x%0h wdata=0x%0h lat=%0d rdata=0x%0h",
                 p, t, a, d, lat, get_rdata(p));
    endtask

    initial begin
        int         order[$];
        int         done_cnt[2];
        int         left[2];
        int         dual;
        int         bcnt;
        int         rdy;
        int         dcnt;
        int         got;
        int         expv;
        logic       r0;
        logic       r1;
        logic       rv;
        logic       rv_hist[10];
        logic [31:0] hold0;
        int         exp_rv[10] = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 0};

        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        set_req(1, 1'b0, 1'b0, 32'h0, 32'h0);
        bus.done_cache = 1'b0;
        bus.data_out   = 32'h0;

        // reset state
        @(posedge clk);
        @(negedge clk);
        check("rst_req_valid", bus.req_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_grant", bus.grant, 2'b00);
        check("rst_ready", {bus.req1_ready, bus.req0_ready}, 2'b00);
        check("rst_done", {bus.req1_done, bus.req0_done}, 2'b00);
        check("rst_address", bus.address, 32'h0);
        check("rst_data_in", bus.data_in, 32'h0);
        check("rst_req_type", bus.req_type, 1'b0);
        check("rst_rdata0", bus.req0_rdata, 32'h0);
        check("rst_rdata1", bus.req1_rdata, 32'h0);
        next_cycle();
        rst = 1'b1;

        // simultaneous requests, four per port
        left     = '{4, 4};
        done_cnt = '{0, 0};
        dual     = 0;
        bcnt     = 0;
        set_req(0, 1'b1, 1'b0, 32'h200, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h300, 32'h0);
        for (int c = 0; c < 300 && (done_cnt[0] + done_cnt[1]) < 8; c++) begin
            @(negedge clk);
            r0 = bus.req0_ready;
            r1 = bus.req1_ready;
            rv = bus.req_valid;
            if (r0 && r1) dual++;
            if (r0) begin order.push_back(0); $display("txn accept port=0 cycle=%0d", c); end
            if (r1) begin order.push_back(1); $display("txn accept port=1 cycle=%0d", c); end
            if (bus.req0_done) done_cnt[0]++;
            if (bus.req1_done) done_cnt[1]++;
            bcnt = rv ? bcnt + 1 : 0;
            next_cycle();
            bus.done_cache = (bcnt == 1);
            bus.data_out   = 32'hA000_0000 + 32'(c);
            if (r0) begin left[0]--; if (left[0] == 0) bus.req0_valid = 1'b0; end
            if (r1) begin left[1]--; if (left[1] == 0) bus.req1_valid = 1'b0; end
        end
        bus.done_cache = 1'b0;
        bus.data_out   = 32'h0;
        check("tie_accepts", order.size(), 8);
        check("tie_dual_ready", dual, 0);
        check("tie_done0", done_cnt[0], 4);
        check("tie_done1", done_cnt[1], 4);
        for (int i = 0; i < 8; i++) begin
            got = (i < order.size()) ? order[i] : 9;
`ifdef ARB_ROUND_ROBIN_EN
            expv = i % 2;
`else
            expv = (i < 4) ? 0 : 1;
`endif
            check($sformatf("tie_order%0d", i), got, expv);
        end
        next_cycle();

        // single read
        run_txn(0, 1'b0, 32'h0000_0040, 32'h0, 3, 32'hDEAD_BEEF);

        // write on port 1, valid dropped after accept
        run_txn(1, 1'b1, 32'h0000_0100, 32'h1234_5678, 3, 32'h5555_AAAA);

        // back-to-back with same-cycle cache completion
        rdy  = 0;
        dcnt = 0;
        set_req(0, 1'b1, 1'b0, 32'h80, 32'h0);
        for (int c = 0; c < 10; c++) begin
            #1;
            bus.done_cache = bus.req_valid;
            bus.data_out   = 32'hB000_0000 + 32'(c);
            @(negedge clk);
            r0 = bus.req0_ready;
            if (r0) rdy++;
            if (bus.req0_done) dcnt++;
            rv_hist[c] = bus.req_valid;
            next_cycle();
            if (r0 && rdy == 3) bus.req0_valid = 1'b0;
        end
        bus.done_cache = 1'b0;
        bus.data_out   = 32'h0;
        for (int c = 0; c < 10; c++) begin
            check($sformatf("b2b_req_valid%0d", c), rv_hist[c], exp_rv[c][0]);
        end
        check("b2b_ready_count", rdy, 3);
        check("b2b_done_count", dcnt, 3);
        $display("txn back_to_back readies=%0d dones=%0d", rdy, dcnt);

        // stray done while idle
        hold0          = bus.req0_rdata;
        bus.done_cache = 1'b1;
        bus.data_out   = 32'hFFFF_0000;
        @(negedge clk);
        check("stray_busy", bus.busy, 1'b0);
        check("stray_req_valid", bus.req_valid, 1'b0);
        next_cycle();
        bus.done_cache = 1'b0;
        bus.data_out   = 32'h0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("stray_no_done", {bus.req1_done, bus.req0_done}, 2'b00);
            check("stray_still_idle", bus.busy, 1'b0);
            check("stray_rdata0", bus.req0_rdata, hold0);
            next_cycle();
        end
        $display("txn stray_done rdata0=0x%0h", bus.req0_rdata);

        // reset while busy
        set_req(0, 1'b1, 1'b0, 32'h44, 32'h0);
        @(negedge clk);
        check("rmid_ready", bus.req0_ready, 1'b1);
        next_cycle();
        set_req(0, 1'b0, 1'b0, 32'h0, 32'h0);
        @(negedge clk);
        check("rmid_busy_before", bus.busy, 1'b1);
        next_cycle();
        rst = 1'b0;
        #1;
        check("rmid_req_valid", bus.req_valid, 1'b0);
        check("rmid_busy", bus.busy, 1'b0);
        check("rmid_grant", bus.grant, 2'b00);
        check("rmid_address", bus.address, 32'h0);
        check("rmid_rdata0", bus.req0_rdata, 32'h0);
        bus.done_cache = 1'b1;
        next_cycle();
        bus.done_cache = 1'b0;
        next_cycle();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("rmid_no_done", {bus.req1_done, bus.req0_done}, 2'b00);
            check("rmid_idle", bus.busy, 1'b0);
            next_cycle();
        end
        $display("txn reset_mid_busy discarded");
        run_txn(0, 1'b0, 32'h48, 32'h0, 2, 32'hCAFE_F00D);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
